// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and pipeline control: load-use stall, branch flush
// with optional redirect delay, memory-wait freeze, and debug counters.
//
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   IF_ID_readREG1/2 : source registers of the ID instruction
//   IF_ID_use1/2     : ID instruction actually reads readREG1/2
//   ID_EX_memread    : EX instruction is a load
//   ID_EX_writeREG   : destination register of the EX instruction
//   branch_taken     : EX-stage branch/jump resolved taken (pulse)
//   mem_wait         : memory not ready, freeze the pipeline
//   PCwrite          : PC register enable
//   IF_ID_write      : IF/ID register enable
//   IF_ID_flush      : IF/ID clear to NOP
//   ID_EX_bubble     : zero the ID/EX control fields
//   EX_MEM_write     : EX/MEM and MEM/WB register enable
//   stall_cnt        : saturating count of load-use stall cycles
//   flush_cnt        : saturating count of branch flush events
//   busy             : state is not RUN
module hazard_ctrl_unit #(
    parameter int REG_W    = 3,
    parameter int CNT_W    = 16,
    parameter int BR_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_readREG1,
    input  logic [REG_W-1:0] IF_ID_readREG2,
    input  logic             IF_ID_use1,
    input  logic             IF_ID_use2,
    input  logic             ID_EX_memread,
    input  logic [REG_W-1:0] ID_EX_writeREG,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             PCwrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRDLY = 2'd1,
        MWAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] dly_q;
    logic [1:0] dly_nxt;
    logic       lu;
    logic       inc_stall;
    logic       inc_flush;

    // x0 is hardwired zero, so a load targeting it is never a hazard.
    assign lu = ID_EX_memread
             && (ID_EX_writeREG != '0)
             && ((IF_ID_use1 && (IF_ID_readREG1 == ID_EX_writeREG))
              || (IF_ID_use2 && (IF_ID_readREG2 == ID_EX_writeREG)));

    assign busy = (state != RUN);

    always_comb begin
        PCwrite      = 1'b1;
        IF_ID_write  = 1'b1;
        EX_MEM_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        state_nxt    = state;
        dly_nxt      = dly_q;
        inc_stall    = 1'b0;
        inc_flush    = 1'b0;
        // In reset the outputs stay at their no-hazard values even if
        // the inputs are asserted.
        if (rst_n) begin
            unique case (1'b1)
                (state == BRDLY): begin
                    if (mem_wait) begin
                        PCwrite      = 1'b0;
                        IF_ID_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                    end else begin
                        IF_ID_flush = 1'b1;
                        dly_nxt     = dly_q - 2'd1;
                        if (dly_q <= 2'd1) begin
                            state_nxt = RUN;
                        end
                    end
                end
                (state == MWAIT && mem_wait): begin
                    PCwrite      = 1'b0;
                    IF_ID_write  = 1'b0;
                    EX_MEM_write = 1'b0;
                end
                default: begin
                    // RUN, or the release cycle out of MWAIT, which is
                    // evaluated exactly like RUN.
                    state_nxt = RUN;
                    priority case (1'b1)
                        mem_wait: begin
                            PCwrite      = 1'b0;
                            IF_ID_write  = 1'b0;
                            EX_MEM_write = 1'b0;
                            state_nxt    = MWAIT;
                        end
                        branch_taken: begin
                            IF_ID_flush  = 1'b1;
                            ID_EX_bubble = 1'b1;
                            inc_flush    = 1'b1;
                            if (BR_DELAY > 0) begin
                                dly_nxt   = 2'(BR_DELAY);
                                state_nxt = BRDLY;
                            end
                        end
                        lu: begin
                            PCwrite      = 1'b0;
                            IF_ID_write  = 1'b0;
                            ID_EX_bubble = 1'b1;
                            inc_stall    = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            dly_q     <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            dly_q <= dly_nxt;
            if (inc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (inc_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Hazard detection and pipeline-control block for the 5-stage CPU (8 registers, 3-bit register addresses).
- Works on the stall/flush side of the hazard logic, alongside the EX-stage forwarding unit. It covers the cases that forwarding cannot resolve:
  - load-use dependences, by stalling IF/ID and inserting an ID/EX bubble;
  - taken branches resolved in EX, by flushing IF/ID and ID/EX, plus an optional registered redirect delay;
  - external memory wait, by freezing the whole pipeline.
- Keeps saturating stall and flush counters for debug.

Parameters:
REG_W, 3, register-address width
CNT_W, 16, width of the stall and flush counters
BR_DELAY, 0, extra IF/ID flush cycles after branch resolution (legal 0..3)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
IF_ID_readREG1  in  REG_W  rs of instruction in ID
IF_ID_readREG2  in  REG_W  rt of instruction in ID
IF_ID_use1  in  1  ID instruction reads readREG1
IF_ID_use2  in  1  ID instruction reads readREG2
ID_EX_memread  in  1  instruction in EX is a load
ID_EX_writeREG  in  REG_W  destination of instruction in EX
branch_taken  in  1  EX-stage branch/jump resolved taken (single-cycle pulse)
mem_wait  in  1  data/instruction memory not ready
PCwrite  out  1  PC register enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  IF/ID clear to NOP
ID_EX_bubble  out  1  ID/EX control fields forced to zero
EX_MEM_write  out  1  EX/MEM and MEM/WB register enable
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch flush events, saturating
busy  out  1  state is not RUN

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, delay counter=0, stall_cnt=0, flush_cnt=0. While in reset, control outputs take their RUN/no-hazard values: PCwrite=1, IF_ID_write=1, EX_MEM_write=1, IF_ID_flush=0, ID_EX_bubble=0, busy=0.
- Control outputs are combinational from the state and the current inputs. The counters and the state are registered.
- Load-use hit (lu), evaluated only in RUN:
  - lu = ID_EX_memread && ID_EX_writeREG!=0 && ((IF_ID_use1 && readREG1==ID_EX_writeREG) || (IF_ID_use2 && readREG2==ID_EX_writeREG)).
- States:
  - RUN.
  - BRDLY: extra redirect flush, only reachable when BR_DELAY>0.
  - MWAIT: memory freeze.
- Priority each cycle: mem_wait > branch_taken > lu.
- RUN, mem_wait=1:
  - Outputs: PCwrite=0, IF_ID_write=0, EX_MEM_write=0, no flush, no bubble.
  - Next state MWAIT.
  - A branch_taken or lu in this cycle is ignored; upstream holds those signals stable until the freeze ends.
- RUN, branch_taken=1:
  - Outputs: IF_ID_flush=1, ID_EX_bubble=1, PCwrite=1.
  - flush_cnt += 1 (saturating).
  - If BR_DELAY>0: delay counter loads BR_DELAY, next state BRDLY.
  - lu is ignored, because the instruction in ID is being squashed.
- RUN, lu=1:
  - Outputs: PCwrite=0, IF_ID_write=0, ID_EX_bubble=1.
  - stall_cnt += 1 (saturating).
  - Stays in RUN. The bubble clears ID_EX_memread the next cycle, so the stall lasts exactly 1 cycle.
- RUN, no event: all enables=1, no flush, no bubble.
- BRDLY:
  - Outputs: IF_ID_flush=1, PCwrite=1, ID_EX_bubble=0.
  - Delay counter decrements; on the cycle it reaches 1, next state RUN.
  - lu is ignored.
  - mem_wait in BRDLY freezes the pipeline (all enables=0, flush=0) and holds the counter. Stay in BRDLY.
  - A new branch_taken cannot arrive, since EX holds a bubble.
- MWAIT:
  - All enables=0, no flush, no bubble.
  - Return to RUN on the first cycle mem_wait=0. That cycle is evaluated as RUN: re-checks branch_taken and lu.
- Counters saturate at 2^CNT_W-1 and never wrap.
- busy = (state != RUN).
- Register 0 is never a hazard source: ID_EX_writeREG=0 never stalls.

Test Plan:
- Load-use: ID_EX_memread=1, ID_EX_writeREG=3, readREG1=3, use1=1 for 1 cycle -> PCwrite=0, IF_ID_write=0, ID_EX_bubble=1 in that cycle; stall_cnt 0->1; next cycle with memread=0, all enables=1.
- Zero register and unused operand:
  - writeREG=0 with readREG1=0 -> no stall.
  - writeREG=5, readREG2=5, use2=0 -> no stall; stall_cnt stays 0.
- Branch with lu in the same cycle, BR_DELAY=0: branch_taken=1 and lu=1 -> IF_ID_flush=1, ID_EX_bubble=1, PCwrite=1; flush_cnt=1, stall_cnt=0; state stays RUN.
- BR_DELAY=2: branch_taken pulse at T:
  - T: IF_ID_flush=1, ID_EX_bubble=1.
  - T+1, T+2: IF_ID_flush=1, busy=1.
  - T+3: busy=0, flush=0.
- mem_wait=1 for 3 cycles while lu is held -> enables=0 and counters unchanged for 3 cycles; first cycle after release: lu stall asserted, stall_cnt +1.
- Saturation and reset:
  - CNT_W=2: 5 load-use events -> stall_cnt=3.
  - rst_n pulled low mid-BRDLY, asynchronous -> busy=0, counters=0, PCwrite=1 immediately, without waiting for clk.
